// File: rtl/alu_ops_pkg.sv
// Operation encoding shared with the ALU controller, plus the execution-unit FSM states.
package alu_ops_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_XOR = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_SLT = 4'b0101,
        OP_SRA = 4'b0110,
        OP_SRL = 4'b0111,
        OP_SLL = 4'b1000,
        OP_BNE = 4'b1010,
        OP_BLT = 4'b1011,
        OP_BGE = 4'b1100,
        OP_BEQ = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        case (op)
            OP_SRA, OP_SRL, OP_SLL: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads on start, done is high during the cycle whose
// edge applies the final bit, so result is the fully shifted value at that edge.
module alu_shift_iter
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             op,
    input  logic [DATA_WIDTH-1:0]  operand,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result
);

    localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = {SHAMT_WIDTH{1'b0}};
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]  work_r;
    logic [SHAMT_WIDTH-1:0] cnt_r;
    logic                   left_r;
    logic                   arith_r;
    logic [DATA_WIDTH-1:0]  step_s;

    // Single-bit step; arithmetic right shifts replicate the MSB, which still holds the original sign.
    always_comb begin
        step_s = work_r;
        if (left_r) begin
            step_s = {work_r[DATA_WIDTH-2:0], 1'b0};
        end else if (arith_r) begin
            step_s = {work_r[DATA_WIDTH-1], work_r[DATA_WIDTH-1:1]};
        end else begin
            step_s = {1'b0, work_r[DATA_WIDTH-1:1]};
        end
    end

    // Working register and remaining-shift counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r  <= {DATA_WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            left_r  <= 1'b0;
            arith_r <= 1'b0;
        end else if (start) begin
            work_r  <= operand;
            cnt_r   <= shamt;
            left_r  <= (op == OP_SLL);
            arith_r <= (op == OP_SRA);
        end else if (cnt_r != CNT_ZERO) begin
            work_r <= step_s;
            cnt_r  <= cnt_r - CNT_ONE;
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    assign done   = (cnt_r == CNT_ONE);
    assign result = step_s;

endmodule

// File: rtl/alu_iterative.sv
// EX-stage execution unit with valid/ready handshakes on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts instead of the iterative shifter.
module alu_iterative
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  illegal_op
);

    alu_state_t                state_r;
    logic [DATA_WIDTH-1:0]     result_r;
    logic                      illegal_r;
    logic [DATA_WIDTH-1:0]     result_s;
    logic                      illegal_s;
    logic [SHAMT_WIDTH-1:0]    shamt_s;
    logic                      lt_s;
    logic                      eq_s;

    assign shamt_s = SrcB[SHAMT_WIDTH-1:0];
    assign lt_s    = ($signed(SrcA) < $signed(SrcB));
    assign eq_s    = (SrcA == SrcB);

    // Single-cycle result; in the iterative build shifts yield SrcA, which is the shamt-0 answer.
    always_comb begin
        result_s  = {DATA_WIDTH{1'b0}};
        illegal_s = 1'b0;
        case (Operation)
            OP_ADD: result_s = SrcA + SrcB;
            OP_SUB: result_s = SrcA - SrcB;
            OP_XOR: result_s = SrcA ^ SrcB;
            OP_OR:  result_s = SrcA | SrcB;
            OP_AND: result_s = SrcA & SrcB;
            OP_SLT: result_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
`ifdef ALU_BARREL_SHIFT_EN
            OP_SRA: result_s = $unsigned($signed(SrcA) >>> shamt_s);
            OP_SRL: result_s = SrcA >> shamt_s;
            OP_SLL: result_s = SrcA << shamt_s;
`else
            OP_SRA, OP_SRL, OP_SLL: result_s = SrcA;
`endif
            OP_BNE: result_s = {{(DATA_WIDTH-1){1'b0}}, ~eq_s};
            OP_BLT: result_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            OP_BGE: result_s = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
            OP_BEQ: result_s = {{(DATA_WIDTH-1){1'b0}}, eq_s};
            default: begin
                result_s  = {DATA_WIDTH{1'b0}};
                illegal_s = 1'b1;
            end
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic                  shift_start_s;
    logic                  shift_done_s;
    logic [DATA_WIDTH-1:0] shift_result_s;

    assign shift_start_s = in_valid && (state_r == IDLE) && is_shift_op(Operation)
                           && (shamt_s != {SHAMT_WIDTH{1'b0}});

    alu_shift_iter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .start   (shift_start_s),
        .op      (Operation),
        .operand (SrcA),
        .shamt   (shamt_s),
        .done    (shift_done_s),
        .result  (shift_result_s)
    );
`endif

    // Control FSM with registered result and illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            result_r  <= {DATA_WIDTH{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        result_r  <= result_s;
                        illegal_r <= illegal_s;
`ifdef ALU_BARREL_SHIFT_EN
                        state_r   <= DONE;
`else
                        state_r   <= shift_start_s ? SHIFT : DONE;
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    if (shift_done_s) begin
                        result_r  <= shift_result_s;
                        illegal_r <= 1'b0;
                        state_r   <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign ALUResult  = result_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed vector table plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_iterative;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    alu_iterative #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Operation  (Operation),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
        int exp_lat;
        int lat;
        logic [4:0] sh;
        sh = b[4:0];
        exp_lat = 1;
`ifndef ALU_BARREL_SHIFT_EN
        if ((op == 4'b0110 || op == 4'b0111 || op == 4'b1000) && sh != 5'd0)
            exp_lat = int'(sh) + 1;
`endif
        check({name, " in_ready before"}, {31'd0, in_ready}, 32'd1);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, ALUResult, exp_res);
        check({name, " illegal"}, {31'd0, illegal_op}, {31'd0, exp_ill});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
        check({name, " out_valid after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int hits;

        vecs[0]  = '{"add",        4'b0000, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{"add wrap",   4'b0000, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0};
        vecs[2]  = '{"sub",        4'b0001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[3]  = '{"xor",        4'b0010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0};
        vecs[4]  = '{"or",         4'b0011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0};
        vecs[5]  = '{"and",        4'b0100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
        vecs[6]  = '{"slt -1<1",   4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[7]  = '{"slt 1<-1",   4'b0101, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[8]  = '{"sra 4",      4'b0110, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0};
        vecs[9]  = '{"srl 4",      4'b0111, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0};
        vecs[10] = '{"sll 31",     4'b1000, 32'd1,          32'd31,         32'h8000_0000,  1'b0};
        vecs[11] = '{"sll 0",      4'b1000, 32'h0000_1234,  32'd0,          32'h0000_1234,  1'b0};
        vecs[12] = '{"sra hi b",   4'b0110, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000,  1'b0};
        vecs[13] = '{"srl 31",     4'b0111, 32'hFFFF_FFFF,  32'd31,         32'd1,          1'b0};
        vecs[14] = '{"sra pos 1",  4'b0110, 32'h7000_0000,  32'd1,          32'h3800_0000,  1'b0};
        vecs[15] = '{"beq 9,9",    4'b1101, 32'd9,          32'd9,          32'd1,          1'b0};
        vecs[16] = '{"bne 9,9",    4'b1010, 32'd9,          32'd9,          32'd0,          1'b0};
        vecs[17] = '{"blt -1,1",   4'b1011, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[18] = '{"bge -1,1",   4'b1100, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[19] = '{"bge 5,5",    4'b1100, 32'd5,          32'd5,          32'd1,          1'b0};
        vecs[20] = '{"bne 1,2",    4'b1010, 32'd1,          32'd2,          32'd1,          1'b0};
        vecs[21] = '{"ill 1110",   4'b1110, 32'd5,          32'd7,          32'd0,          1'b1};
        vecs[22] = '{"ill 1001",   4'b1001, 32'd5,          32'd7,          32'd0,          1'b1};
        vecs[23] = '{"ill 1111",   4'b1111, 32'hFFFF_FFFF,  32'd3,          32'd0,          1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'b0000;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset in_ready",  {31'd0, in_ready},   32'd1);
        check("reset out_valid", {31'd0, out_valid},  32'd0);
        check("reset result",    ALUResult,           32'd0);
        check("reset illegal",   {31'd0, illegal_op}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill);
        end

        // Backpressure: result held for 3 cycles, new request ignored meanwhile.
        Operation = 4'b0000;
        SrcA      = 32'd10;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Operation = 4'b0001;
        SrcA      = 32'd100;
        SrcB      = 32'd1;
        for (int c = 0; c < 3; c++) begin
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp result",    ALUResult,          32'd30);
            check("bp in_ready",  {31'd0, in_ready},  32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp in_ready after",  {31'd0, in_ready},  32'd1);
        check("bp out_valid after", {31'd0, out_valid}, 32'd0);
        run_op("add after bp", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);

        // Reset in the middle of a long shift abandons it.
        Operation = 4'b1000;
        SrcA      = 32'd1;
        SrcB      = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid in_ready",  {31'd0, in_ready},  32'd1);
        check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        hits = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid) hits++;
            @(negedge clk);
        end
        check("rst mid no out_valid", hits, 32'd0);
        run_op("add 1+1 after rst", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Sequential execution unit on the consumer side of the 4-bit `Operation` code produced by the ALU controller. It accepts one operation with its operands through a valid/ready handshake and executes it. Shifts iterate one bit per cycle. It returns the result, or a branch-taken bit, through a second valid/ready handshake. It sits in the EX stage in place of a purely combinational ALU.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default $clog2(DATA_WIDTH): shift-amount width, taken from `SrcB[SHAMT_WIDTH-1:0]`.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: operation and operands are presented.
- `in_ready`, output, 1: unit can accept an operation.
- `Operation`, input, 4: operation code (encoding under Operation).
- `SrcA`, input, DATA_WIDTH: operand A.
- `SrcB`, input, DATA_WIDTH: operand B, or shift amount for shifts.
- `out_valid`, output, 1: `ALUResult` and `illegal_op` are valid.
- `out_ready`, input, 1: consumer accepts the result.
- `ALUResult`, output, DATA_WIDTH: computed result. Branch ops return 0 or 1.
- `illegal_op`, output, 1: the completed operation code was unassigned.

## Operation
- Encoding:
  - 0000 add
  - 0001 sub
  - 0010 xor
  - 0011 or
  - 0100 and
  - 0101 slt (signed)
  - 0110 sra
  - 0111 srl
  - 1000 sll
  - 1010 bne
  - 1011 blt (signed)
  - 1100 bge (signed)
  - 1101 beq
  - 1001, 1110, 1111 illegal.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch operands and code. Non-shift ops, illegal codes and shifts with shamt 0 go to DONE. Other shifts go to SHIFT.
  - SHIFT: shift the working register 1 bit per cycle and decrement the counter. When the counter reaches 1, the final shift is applied and the FSM goes to DONE.
  - DONE: `out_valid`=1. Result is held stable while `out_ready`=0. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE, so at most one operation is in flight.
- Arithmetic wraps modulo 2^DATA_WIDTH and no overflow is flagged.
- slt, blt and bge compare two's-complement operands. Branch ops return `{DATA_WIDTH-1 zeros, taken}`.
- sra shifts in the sign bit of `SrcA`. srl and sll shift in zeros.
- Only the low `SHAMT_WIDTH` bits of `SrcB` are used.
- Illegal code: `ALUResult`=0 and `illegal_op`=1, with the same latency as a non-shift op.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `ALUResult`=0, `illegal_op`=0, shift counter 0.
- Reset mid-operation (in SHIFT or DONE): the operation is abandoned. No `out_valid` is produced for it, and the FSM is in IDLE on the next cycle.
- `in_valid` asserted while `in_ready`=0 is ignored. The producer holds its inputs until a handshake occurs.

## Timing
- Non-shift op accepted at edge N: `out_valid`=1 from cycle N+1.
- Shift with shamt k>0 (iterative build): `out_valid`=1 from cycle N+k+1.
- Maximum latency is DATA_WIDTH cycles (shamt DATA_WIDTH-1).
- Result handshake at edge M: `in_ready`=1 from cycle M+1.
- Minimum issue interval is 2 cycles.
- `ALUResult` and `illegal_op` are registered outputs with no combinational path from inputs.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - Shifts use a single-cycle barrel shifter and always go IDLE→DONE with latency 1.
  - The SHIFT state and shift counter are not built.
- `ALU_BARREL_SHIFT_EN` undefined: iterative shifting as specified above.

## Structure
- Package `alu_ops_pkg`:
  - enum `alu_op_t` holding the 4-bit encoding above, shared with the ALU controller;
  - FSM state enum `alu_state_t` (IDLE, SHIFT, DONE).
- Sub-module `alu_shift_iter` holds the working register, counter and direction/arithmetic control. It exposes `start`, `done` and `result`, and is omitted under `ALU_BARREL_SHIFT_EN`.

## Test plan
1. add: `SrcA`=5, `SrcB`=7 → `ALUResult`=12, `out_valid` one cycle after accept, `illegal_op`=0.
2. sub: 3−5 → `ALUResult`=0xFFFF_FFFE. slt: −1 vs 1 → 1.
3. sra: 0x8000_0000 by 4 → 0xF800_0000 at 5 cycles after accept (1 with `ALU_BARREL_SHIFT_EN`). srl of the same operands → 0x0800_0000.
4. Branch ops:
   - beq 9,9 → 1;
   - bne 9,9 → 0;
   - blt 0xFFFF_FFFF,1 → 1;
   - bge 0xFFFF_FFFF,1 → 0.
5. Backpressure and illegal code:
   - hold `out_ready`=0 for 3 cycles → result stable, `in_ready`=0, new `in_valid` ignored;
   - code 1110 → `ALUResult`=0, `illegal_op`=1.
6. Assert `reset` during an sll of shamt 20 at cycle 5 → no `out_valid`, `in_ready`=1 next cycle, and a following add 1+1 returns 2.
